execute_stage: RTL and testbench

Execute stage of the 16-bit five-stage pipeline, between the ID/EX register and the memory stage. It forwards operands, runs the ALU, resolves branches and jumps, and owns the EX/MEM pipeline register that drives the memory stage's `*M` inputs. An optional iterative multiply/divide unit stalls the front end while it runs.

---
 rtl/execute_stage_pkg.sv | 42 ++++
 rtl/execute_stage_if.sv | 32 +++
 rtl/execute_stage_mdu_iter.sv | 93 +++++++++
 rtl/execute_stage.sv | 128 ++++++++++++
 tb/tb_execute_stage.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/execute_stage_pkg.sv
// Shared types and constants for the execute stage and its iterative multiply/divide unit.
package ex_pkg;

    localparam int DATA_W    = 16;
    localparam int REG_W     = 4;
    localparam int MDU_STEPS = 16;
    localparam int CNT_W     = $clog2(MDU_STEPS) + 1;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_SLL  = 4'h5,
        OP_SRL  = 4'h6,
        OP_SRA  = 4'h7,
        OP_SLT  = 4'h8,
        OP_SLTU = 4'h9,
        OP_MUL  = 4'hA,
        OP_DIVU = 4'hB,
        OP_REMU = 4'hC
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_RSV = 2'b11
    } fwd_sel_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_RUN  = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    function automatic logic is_muldiv(input alu_op_e op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX inputs, forwarding controls and EX/MEM outputs of the execute stage.
interface execute_stage_if;
    logic        regWriteE, memWriteE, aluSrcE, branchE, jumpE;
    logic [1:0]  resultSrcE;
    logic [3:0]  aluCtrlE;
    logic [15:0] rd1E, rd2E, immE, PCE, PCPlus2E;
    logic [3:0]  RdE;
    logic [1:0]  forwardAE, forwardBE;
    logic [15:0] resultW;

    logic        regWriteM, memWriteM;
    logic [1:0]  resultSrcM;
    logic [15:0] aluResM, writeDataM, PCPlus2M;
    logic [3:0]  RdM;
    logic        PCSrcE;
    logic [15:0] PCTargetE;
    logic        exBusy;

    modport master (
        output regWriteE, memWriteE, aluSrcE, branchE, jumpE, resultSrcE, aluCtrlE,
               rd1E, rd2E, immE, PCE, PCPlus2E, RdE, forwardAE, forwardBE, resultW,
        input  regWriteM, memWriteM, resultSrcM, aluResM, writeDataM, PCPlus2M, RdM,
               PCSrcE, PCTargetE, exBusy
    );

    modport slave (
        input  regWriteE, memWriteE, aluSrcE, branchE, jumpE, resultSrcE, aluCtrlE,
               rd1E, rd2E, immE, PCE, PCPlus2E, RdE, forwardAE, forwardBE, resultW,
        output regWriteM, memWriteM, resultSrcM, aluResM, writeDataM, PCPlus2M, RdM,
               PCSrcE, PCTargetE, exBusy
    );
endinterface

// File: rtl/execute_stage_mdu_iter.sv
// Iterative 16-step shift-add multiplier and restoring divider (low product, quotient, remainder).
module mdu_iter
    import ex_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  alu_op_e           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    mdu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    alu_op_e           op_q, op_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W:0]   rem_sh, rem_diff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_ADD;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    // For divide, acc holds the partial remainder and a shifts the dividend out / quotient in.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        acc_d    = acc_q;
        a_d      = a_q;
        b_d      = b_q;
        rem_sh   = {acc_q, a_q[DATA_W-1]};
        rem_diff = rem_sh - {1'b0, b_q};
        case (state_q)
            MDU_IDLE: begin
                if (start) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = MDU_RUN;
                end
            end
            MDU_RUN: begin
                if (op_q == OP_MUL) begin
                    if (b_q[0]) begin
                        acc_d = acc_q + a_q;
                    end
                    a_d = a_q << 1;
                    b_d = b_q >> 1;
                end else begin
                    a_d = {a_q[DATA_W-2:0], 1'b0};
                    if (rem_sh >= {1'b0, b_q}) begin
                        acc_d  = rem_diff[DATA_W-1:0];
                        a_d[0] = 1'b1;
                    end else begin
                        acc_d = rem_sh[DATA_W-1:0];
                    end
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(MDU_STEPS - 1)) begin
                    state_d = MDU_DONE;
                end
            end
            MDU_DONE: state_d = MDU_IDLE;
            default:  state_d = MDU_IDLE;
        endcase
    end

    assign busy   = ((state_q == MDU_IDLE) && start) || (state_q == MDU_RUN);
    assign done   = (state_q == MDU_DONE);
    assign result = (op_q == OP_DIVU) ? a_q : acc_q;

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution and the EX/MEM register.
// Define EX_MULDIV_EN to build the iterative multiply/divide unit (opcodes A-C stall the front end).
module execute_stage
    import ex_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    execute_stage_if.slave ex
);

    function automatic logic [DATA_W-1:0] fwd_mux(input logic [1:0] sel,
                                                   input logic [DATA_W-1:0] rf,
                                                   input logic [DATA_W-1:0] wb,
                                                   input logic [DATA_W-1:0] mem);
        case (fwd_sel_e'(sel))
            FWD_WB:  return wb;
            FWD_MEM: return mem;
            default: return rf;
        endcase
    endfunction

    // Multiply/divide opcodes yield 0 here; the MDU supplies their result when built.
    function automatic logic [DATA_W-1:0] alu(input alu_op_e op,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
        logic signed [DATA_W-1:0] sa;
        logic signed [DATA_W-1:0] sb;
        sa = a;
        sb = b;
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLL:  return a << b[3:0];
            OP_SRL:  return a >> b[3:0];
            OP_SRA:  return sa >>> b[3:0];
            OP_SLT:  return {{(DATA_W-1){1'b0}}, (sa < sb)};
            OP_SLTU: return {{(DATA_W-1){1'b0}}, (a < b)};
            default: return '0;
        endcase
    endfunction

    alu_op_e           op;
    logic [DATA_W-1:0] src_a, fwd_b, src_b, alu_res, ex_res;
    logic              ex_busy, vld_p0;

    logic              reg_write_p1, mem_write_p1;
    logic [1:0]        result_src_p1;
    logic [DATA_W-1:0] alu_res_p1, write_data_p1, pc_plus2_p1;
    logic [REG_W-1:0]  rd_p1;

    assign op      = alu_op_e'(ex.aluCtrlE);
    assign src_a   = fwd_mux(ex.forwardAE, ex.rd1E, ex.resultW, alu_res_p1);
    assign fwd_b   = fwd_mux(ex.forwardBE, ex.rd2E, ex.resultW, alu_res_p1);
    assign src_b   = ex.aluSrcE ? ex.immE : fwd_b;
    assign alu_res = alu(op, src_a, src_b);

    assign ex.PCTargetE = ex.PCE + ex.immE;
    assign ex.PCSrcE    = ex.jumpE | (ex.branchE & (alu_res == '0));

`ifdef EX_MULDIV_EN
    logic              mdu_start, mdu_busy, mdu_done;
    logic [DATA_W-1:0] mdu_res;

    assign mdu_start = is_muldiv(op);

    mdu_iter u_mdu (
        .clk    (clk),
        .rst    (rst),
        .start  (mdu_start),
        .op     (op),
        .a      (src_a),
        .b      (src_b),
        .busy   (mdu_busy),
        .done   (mdu_done),
        .result (mdu_res)
    );

    assign ex_busy = mdu_busy;
    assign ex_res  = mdu_done ? mdu_res : alu_res;
`else
    assign ex_busy = 1'b0;
    assign ex_res  = alu_res;
`endif

    assign ex.exBusy = ex_busy;
    assign vld_p0    = ~ex_busy;

    // EX -> MEM boundary: a stalled cycle inserts a bubble with all control and data cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write_p1  <= 1'b0;
            mem_write_p1  <= 1'b0;
            result_src_p1 <= '0;
            alu_res_p1    <= '0;
            write_data_p1 <= '0;
            pc_plus2_p1   <= '0;
            rd_p1         <= '0;
        end else if (vld_p0) begin
            reg_write_p1  <= ex.regWriteE;
            mem_write_p1  <= ex.memWriteE;
            result_src_p1 <= ex.resultSrcE;
            alu_res_p1    <= ex_res;
            write_data_p1 <= fwd_b;
            pc_plus2_p1   <= ex.PCPlus2E;
            rd_p1         <= ex.RdE;
        end else begin
            reg_write_p1  <= 1'b0;
            mem_write_p1  <= 1'b0;
            result_src_p1 <= '0;
            alu_res_p1    <= '0;
            write_data_p1 <= '0;
            pc_plus2_p1   <= '0;
            rd_p1         <= '0;
        end
    end

    assign ex.regWriteM  = reg_write_p1;
    assign ex.memWriteM  = mem_write_p1;
    assign ex.resultSrcM = result_src_p1;
    assign ex.aluResM    = alu_res_p1;
    assign ex.writeDataM = write_data_p1;
    assign ex.PCPlus2M   = pc_plus2_p1;
    assign ex.RdM        = rd_p1;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage; expectations follow whether EX_MULDIV_EN is defined.
module tb_execute_stage;
    import ex_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    execute_stage_if bus ();

    execute_stage dut (
        .clk (clk),
        .rst (rst),
        .ex  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] res;
        logic [15:0] wd;
        logic [15:0] pc2;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] last_res = 16'h0;
    logic [15:0] pc2 = 16'h0200;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_vec++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, want);
        end
    endtask

    function automatic logic [15:0] ref_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic signed [15:0] sa;
        logic [31:0]        p;
        sa = a;
        p  = a * b;
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            4'h5: return a << b[3:0];
            4'h6: return a >> b[3:0];
            4'h7: return sa >>> b[3:0];
            4'h8: return ($signed(a) < $signed(b)) ? 16'h1 : 16'h0;
            4'h9: return (a < b) ? 16'h1 : 16'h0;
`ifdef EX_MULDIV_EN
            4'hA: return p[15:0];
            4'hB: return (b == 16'h0) ? 16'hFFFF : a / b;
            4'hC: return (b == 16'h0) ? a : a % b;
`endif
            default: return 16'h0;
        endcase
    endfunction

    function automatic logic [15:0] fwd_model(input logic [1:0] sel, input logic [15:0] rf,
                                              input logic [15:0] wb, input logic [15:0] mem);
        if (sel == 2'b01) return wb;
        if (sel == 2'b10) return mem;
        return rf;
    endfunction

    function automatic int exp_stall(input logic [3:0] op);
`ifdef EX_MULDIV_EN
        return (op inside {4'hA, 4'hB, 4'hC}) ? 17 : 0;
`else
        return 0;
`endif
    endfunction

    task automatic nop();
        bus.regWriteE  = 1'b0;
        bus.memWriteE  = 1'b0;
        bus.aluSrcE    = 1'b0;
        bus.branchE    = 1'b0;
        bus.jumpE      = 1'b0;
        bus.resultSrcE = 2'b00;
        bus.aluCtrlE   = 4'h0;
        bus.rd1E       = 16'h0;
        bus.rd2E       = 16'h0;
        bus.immE       = 16'h0;
        bus.PCE        = 16'h0;
        bus.PCPlus2E   = 16'h0;
        bus.RdE        = 4'h0;
        bus.forwardAE  = 2'b00;
        bus.forwardBE  = 2'b00;
        bus.resultW    = 16'h0;
    endtask

    task automatic drive_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                            input logic use_imm, input logic [15:0] imm);
        bus.regWriteE  = 1'b1;
        bus.memWriteE  = 1'b0;
        bus.resultSrcE = 2'b00;
        bus.branchE    = 1'b0;
        bus.jumpE      = 1'b0;
        bus.aluCtrlE   = op;
        bus.rd1E       = a;
        bus.rd2E       = b;
        bus.aluSrcE    = use_imm;
        bus.immE       = imm;
        bus.RdE        = 4'h5;
        bus.PCPlus2E   = pc2;
        bus.PCE        = pc2 - 16'h2;
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic use_imm, input logic [15:0] imm);
        exp_t        e;
        int          busy_n;
        logic [15:0] ea, eb;
        drive_op(op, a, b, use_imm, imm);
        ea    = fwd_model(bus.forwardAE, a, bus.resultW, last_res);
        eb    = fwd_model(bus.forwardBE, b, bus.resultW, last_res);
        e.tag = tag;
        e.res = ref_alu(op, ea, use_imm ? imm : eb);
        e.wd  = eb;
        e.pc2 = pc2;
        sb.push_back(e);
        #1;
        busy_n = 0;
        while (bus.exBusy === 1'b1 && busy_n < 40) begin
            @(posedge clk);
            #1;
            busy_n++;
            chk({tag, "_bubble"},
                {bus.regWriteM, bus.memWriteM, bus.RdM, bus.aluResM, bus.writeDataM}, 64'h0);
        end
        chk({tag, "_stall"}, 64'(busy_n), 64'(exp_stall(op)));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, "_res"}, bus.aluResM, e.res);
        chk({e.tag, "_wdata"}, bus.writeDataM, e.wd);
        chk({e.tag, "_ctl"}, {bus.regWriteM, bus.RdM, bus.PCPlus2M}, {1'b1, 4'h5, e.pc2});
        last_res = e.res;
        pc2      = pc2 + 16'h2;
    endtask

    initial begin
        nop();
        #12;
        chk("rst_outputs",
            {bus.regWriteM, bus.memWriteM, bus.resultSrcM, bus.RdM, bus.aluResM, bus.writeDataM}, 64'h0);
        chk("rst_pc2", bus.PCPlus2M, 16'h0);
        chk("rst_comb", {bus.PCSrcE, bus.exBusy}, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op("add_ovf",  4'h0, 16'h7FFF, 16'h0000, 1'b1, 16'h0001);
        run_op("slt",      4'h8, 16'h8000, 16'h0001, 1'b0, 16'h0000);
        run_op("sltu",     4'h9, 16'h8000, 16'h0001, 1'b0, 16'h0000);
        run_op("sub_wrap", 4'h1, 16'h0003, 16'h0005, 1'b0, 16'h0000);
        run_op("and",      4'h2, 16'hF0F0, 16'h3C3C, 1'b0, 16'h0000);
        run_op("or",       4'h3, 16'hF0F0, 16'h0F01, 1'b0, 16'h0000);
        run_op("xor",      4'h4, 16'hAAAA, 16'hFFFF, 1'b0, 16'h0000);
        run_op("sll",      4'h5, 16'h0001, 16'h0000, 1'b1, 16'h001F);
        run_op("srl",      4'h6, 16'h8000, 16'h0004, 1'b0, 16'h0000);
        run_op("sra",      4'h7, 16'h8000, 16'h0004, 1'b0, 16'h0000);
        run_op("op_d",     4'hD, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000);
        run_op("op_f",     4'hF, 16'h1234, 16'h5678, 1'b0, 16'h0000);

        bus.forwardAE = 2'b01;
        bus.resultW   = 16'h1234;
        run_op("fwd_a_wb", 4'h0, 16'hDEAD, 16'h0000, 1'b1, 16'h0000);
        bus.forwardAE = 2'b00;
        bus.forwardBE = 2'b10;
        run_op("fwd_b_mem", 4'h0, 16'h0001, 16'hBEEF, 1'b0, 16'h0000);
        bus.forwardBE = 2'b00;
        bus.forwardAE = 2'b11;
        bus.resultW   = 16'h0009;
        run_op("fwd_a_rsv", 4'h0, 16'h0005, 16'h0000, 1'b1, 16'h0010);
        bus.forwardAE = 2'b00;

        run_op("mul",      4'hA, 16'h0012, 16'h0034, 1'b0, 16'h0000);
        run_op("after_mul", 4'h0, 16'h0001, 16'h0001, 1'b0, 16'h0000);
        run_op("divu",     4'hB, 16'd100,  16'd7,    1'b0, 16'h0000);
        run_op("remu",     4'hC, 16'd100,  16'd7,    1'b0, 16'h0000);
        run_op("divu_z",   4'hB, 16'h1234, 16'h0000, 1'b0, 16'h0000);
        run_op("remu_z",   4'hC, 16'h1234, 16'h0000, 1'b0, 16'h0000);
        run_op("mul_ovf",  4'hA, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000);

        nop();
        bus.branchE  = 1'b1;
        bus.aluCtrlE = 4'h1;
        bus.rd1E     = 16'h0042;
        bus.rd2E     = 16'h0042;
        bus.PCE      = 16'h0100;
        bus.immE     = 16'hFFFC;
        #1;
        chk("br_taken", bus.PCSrcE, 1'b1);
        chk("br_target", bus.PCTargetE, 16'h00FC);
        bus.rd2E = 16'h0043;
        #1;
        chk("br_not_taken", bus.PCSrcE, 1'b0);
        bus.jumpE = 1'b1;
        #1;
        chk("jump", bus.PCSrcE, 1'b1);
        nop();
        @(posedge clk);
        #1;

        run_op("pre_rst", 4'h0, 16'h1111, 16'h2222, 1'b0, 16'h0000);
`ifdef EX_MULDIV_EN
        drive_op(4'hA, 16'h0012, 16'h0034, 1'b0, 16'h0000);
        repeat (9) @(posedge clk);
        #1;
        chk("mid_run_busy", bus.exBusy, 1'b1);
`endif
        #1;
        rst = 1'b1;
        nop();
        #1;
        chk("async_rst_outputs",
            {bus.regWriteM, bus.memWriteM, bus.resultSrcM, bus.RdM, bus.aluResM, bus.writeDataM}, 64'h0);
        chk("async_rst_comb", {bus.PCSrcE, bus.exBusy}, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_idle", {bus.regWriteM, bus.aluResM, bus.exBusy}, 64'h0);
        last_res = 16'h0;
        run_op("post_rst_add", 4'h0, 16'h0100, 16'h0023, 1'b0, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
